// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU and DMA request/response channels and the memory-side strobes
// of the shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_done, dma_gnt, dma_done,
    output rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_done, dma_gnt, dma_done,
    input  rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising CPU and DMA accesses onto one memory port.
// Each access walks IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              sel_dma_q, sel_dma_d;
  logic              last_dma_q, last_dma_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dma_done_q, dma_done_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;
  logic              take_s;
  logic              pick_dma_s;

  // Next-state, request selection, field latching and read-data capture
  always_comb begin
    state_d    = state_q;
    sel_dma_d  = sel_dma_q;
    last_dma_d = last_dma_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    take_s     = 1'b0;
    pick_dma_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req && bus.dma_req) begin
          take_s     = 1'b1;
          pick_dma_s = ~last_dma_q;
        end else if (bus.cpu_req) begin
          take_s     = 1'b1;
          pick_dma_s = 1'b0;
        end else if (bus.dma_req) begin
          take_s     = 1'b1;
          pick_dma_s = 1'b1;
        end else begin
          take_s     = 1'b0;
          pick_dma_s = 1'b0;
        end
        if (take_s) begin
          state_d    = ACCESS;
          sel_dma_d  = pick_dma_s;
          last_dma_d = pick_dma_s;
          we_d       = pick_dma_s ? bus.dma_we    : bus.cpu_we;
          addr_d     = pick_dma_s ? bus.dma_addr  : bus.cpu_addr;
          wdata_d    = pick_dma_s ? bus.dma_wdata : bus.cpu_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // mem_rdata is valid only on the final wait cycle of a read
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output pulses are precomputed from the next state so they register in step with it
  always_comb begin
    cpu_gnt_d  = (state_d == ACCESS) && !sel_dma_d;
    dma_gnt_d  = (state_d == ACCESS) &&  sel_dma_d;
    cpu_done_d = (state_d == RESP)   && !sel_dma_d;
    dma_done_d = (state_d == RESP)   &&  sel_dma_d;
    mem_rd_d   = (state_d == ACCESS) && !we_d;
    mem_wr_d   = (state_d == ACCESS) &&  we_d;
    busy_d     = (state_d != IDLE);
  end

  // State, latched access fields and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_dma_q  <= 1'b0;
      last_dma_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      cpu_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_dma_q  <= sel_dma_d;
      last_dma_q <= last_dma_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      cpu_gnt_q  <= cpu_gnt_d;
      dma_gnt_q  <= dma_gnt_d;
      cpu_done_q <= cpu_done_d;
      dma_done_q <= dma_done_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.dma_gnt   = dma_gnt_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dma_done  = dma_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised transaction-level bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  // Memory devices: read data valid only exactly MEM_LAT cycles after the strobe, junk otherwise
  logic [7:0] mem1 [32];
  logic [7:0] mem3 [32];
  logic       p1_v;
  logic [4:0] p1_a;
  logic [2:0] p3_v;
  logic [4:0] p3_a [3];
  logic [7:0] junk_q;
  logic       pl_en;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    junk_q <= 8'($urandom);
    if (reset) begin
      p1_v <= 1'b0;
      p3_v <= 3'b000;
    end else begin
      p1_v <= b1.mem_rd;
      p3_v <= {p3_v[1:0], b3.mem_rd};
    end
    p1_a    <= b1.mem_addr;
    p3_a[0] <= b3.mem_addr;
    p3_a[1] <= p3_a[0];
    p3_a[2] <= p3_a[1];
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (b1.mem_wr) mem1[b1.mem_addr] <= b1.mem_wdata;
      if (b3.mem_wr) mem3[b3.mem_addr] <= b3.mem_wdata;
    end
  end

  assign b1.mem_rdata = p1_v    ? mem1[p1_a]    : junk_q;
  assign b3.mem_rdata = p3_v[2] ? mem3[p3_a[2]] : junk_q;

  // Reference model state: memory contents, last returned read data, round-robin pointer
  logic [7:0] ref1 [32];
  logic [7:0] ref3 [32];
  logic [7:0] m_rdata1;
  logic [7:0] m_rdata3;
  bit         m_last_dma;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 5'd0; b1.cpu_wdata = 8'd0;
    b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = 5'd0; b1.dma_wdata = 8'd0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = 5'd0; b3.cpu_wdata = 8'd0;
    b3.dma_req = 1'b0; b3.dma_we = 1'b0; b3.dma_addr = 5'd0; b3.dma_wdata = 8'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dut1"}, {b1.cpu_gnt, b1.cpu_done, b1.dma_gnt, b1.dma_done, b1.mem_rd,
                             b1.mem_wr, b1.busy, b1.mem_addr, b1.mem_wdata, b1.rdata}, 32'd0);
    check_eq({tag, "_dut3"}, {b3.cpu_gnt, b3.cpu_done, b3.dma_gnt, b3.dma_done, b3.mem_rd,
                             b3.mem_wr, b3.busy, b3.mem_addr, b3.mem_wdata, b3.rdata}, 32'd0);
  endtask

  task automatic model_reset();
    m_rdata1   = 8'h00;
    m_rdata3   = 8'h00;
    m_last_dma = 1'b1;
  endtask

  task automatic model_access1(input bit we, input logic [4:0] a, input logic [7:0] d,
                               output logic [7:0] exp_rd);
    if (we) ref1[a] = d;
    else    m_rdata1 = ref1[a];
    exp_rd = m_rdata1;
  endtask

  // One arbitration round on the MEM_LAT=1 instance; expectations come from the model first
  task automatic run_round(input bit c_en, input bit c_we, input logic [4:0] c_a, input logic [7:0] c_d,
                           input bit d_en, input bit d_we, input logic [4:0] d_a, input logic [7:0] d_d,
                           input bit pulse_dma);
    int t0, n, gcy;
    int g_c = -1, g_d = -1, dn_c = -1, dn_d = -1;
    int e_gc = -1, e_gd = -1, e_dc = -1, e_dd = -1;
    int ng_c = 0, ng_d = 0, nd_c = 0, nd_d = 0;
    logic [7:0] e_rc = 8'h00;
    logic [7:0] e_rd = 8'h00;
    bit ord [2];
    bit exp_busy;
    t0 = cyc;
    n  = 0;
    if (c_en && d_en) begin
      ord[0] = !m_last_dma; ord[1] = m_last_dma; n = 2;
    end else if (c_en) begin
      ord[0] = 1'b0; n = 1;
    end else if (d_en) begin
      ord[0] = 1'b1; n = 1;
    end
    for (int k = 0; k < n; k++) begin
      gcy = t0 + 1 + k * (L1 + 3);
      if (ord[k]) begin
        e_gd = gcy; e_dd = gcy + L1 + 1;
        model_access1(d_we, d_a, d_d, e_rd);
      end else begin
        e_gc = gcy; e_dc = gcy + L1 + 1;
        model_access1(c_we, c_a, c_d, e_rc);
      end
      m_last_dma = ord[k];
    end
    b1.cpu_req = c_en; b1.cpu_we = c_we; b1.cpu_addr = c_a; b1.cpu_wdata = c_d;
    b1.dma_req = d_en; b1.dma_we = d_we; b1.dma_addr = d_a; b1.dma_wdata = d_d;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check_eq("gnt_excl", {31'd0, b1.cpu_gnt & b1.dma_gnt}, 32'd0);
      check_eq("done_excl", {31'd0, b1.cpu_done & b1.dma_done}, 32'd0);
      check_eq("strobe_excl", {31'd0, b1.mem_rd & b1.mem_wr}, 32'd0);
      check_eq("strobe_vs_gnt", {31'd0, b1.mem_rd | b1.mem_wr}, {31'd0, b1.cpu_gnt | b1.dma_gnt});
      exp_busy = (e_gc >= 0 && cyc >= e_gc && cyc <= e_dc) || (e_gd >= 0 && cyc >= e_gd && cyc <= e_dd);
      check_eq("busy", {31'd0, b1.busy}, {31'd0, exp_busy});
      if (b1.cpu_gnt) begin
        g_c = cyc; ng_c++;
        check_eq("cpu_acc", {b1.mem_rd, b1.mem_wr, b1.mem_addr}, {!c_we, c_we, c_a});
        if (c_we) check_eq("cpu_wdata", b1.mem_wdata, c_d);
        b1.cpu_req = 1'b0; b1.cpu_we = 1'($urandom); b1.cpu_addr = 5'($urandom); b1.cpu_wdata = 8'($urandom);
      end
      if (b1.dma_gnt) begin
        g_d = cyc; ng_d++;
        check_eq("dma_acc", {b1.mem_rd, b1.mem_wr, b1.mem_addr}, {!d_we, d_we, d_a});
        if (d_we) check_eq("dma_wdata", b1.mem_wdata, d_d);
        b1.dma_req = 1'b0; b1.dma_we = 1'($urandom); b1.dma_addr = 5'($urandom); b1.dma_wdata = 8'($urandom);
      end
      if (b1.cpu_done) begin
        dn_c = cyc; nd_c++;
        check_eq("cpu_rdata", b1.rdata, e_rc);
      end
      if (b1.dma_done) begin
        dn_d = cyc; nd_d++;
        check_eq("dma_rdata", b1.rdata, e_rd);
      end
      if (pulse_dma && k == 1) b1.dma_req = 1'b1;
      if (pulse_dma && k == 2) b1.dma_req = 1'b0;
    end
    check_eq("cpu_gnt_cnt", ng_c, {31'd0, c_en});
    check_eq("dma_gnt_cnt", ng_d, {31'd0, d_en});
    check_eq("cpu_done_cnt", nd_c, {31'd0, c_en});
    check_eq("dma_done_cnt", nd_d, {31'd0, d_en});
    check_eq("cpu_gnt_cyc", g_c, e_gc);
    check_eq("dma_gnt_cyc", g_d, e_gd);
    check_eq("cpu_done_cyc", dn_c, e_dc);
    check_eq("dma_done_cyc", dn_d, e_dd);
  endtask

  // Single CPU access on the MEM_LAT=3 instance
  task automatic run3(input bit we, input logic [4:0] a, input logic [7:0] d);
    int t0;
    int g = -1, dn = -1, ng = 0, nd = 0;
    logic [7:0] e;
    if (we) ref3[a] = d;
    else    m_rdata3 = ref3[a];
    e  = m_rdata3;
    t0 = cyc;
    b3.cpu_req = 1'b1; b3.cpu_we = we; b3.cpu_addr = a; b3.cpu_wdata = d;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      check_eq("l3_strobe_vs_gnt", {31'd0, b3.mem_rd | b3.mem_wr}, {31'd0, b3.cpu_gnt});
      if (b3.cpu_gnt) begin
        g = cyc; ng++;
        check_eq("l3_acc", {b3.mem_rd, b3.mem_wr, b3.mem_addr, b3.mem_wdata}, {!we, we, a, b3.mem_wdata});
        if (we) check_eq("l3_wdata", b3.mem_wdata, d);
        b3.cpu_req = 1'b0; b3.cpu_addr = 5'($urandom); b3.cpu_wdata = 8'($urandom);
      end
      if (b3.cpu_done) begin
        dn = cyc; nd++;
        check_eq("l3_rdata", b3.rdata, e);
      end
    end
    check_eq("l3_gnt_cnt", ng, 32'd1);
    check_eq("l3_done_cnt", nd, 32'd1);
    check_eq("l3_gnt_cyc", g, t0 + 1);
    check_eq("l3_done_cyc", dn, t0 + L3 + 2);
  endtask

  initial begin : main
    int t0;
    int ng;
    int gcyc [4];
    bit gwho [4];
    int mode;
    logic [7:0] v;

    reset = 1'b1;
    pl_en = 1'b0; pl_addr = 5'd0; pl_data = 8'd0;
    clear_inputs();
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      v = (i == 5) ? 8'hA3 : 8'($urandom);
      pl_en = 1'b1; pl_addr = 5'(i); pl_data = v;
      ref1[i] = v; ref3[i] = v;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    model_reset();
    check_all_zero("reset_vals");
    reset = 1'b0;

    // Both requesters held high straight out of reset: strict alternation, CPU first
    for (int k = 0; k < 4; k++) begin gcyc[k] = -1; gwho[k] = 1'b0; end
    ng = 0;
    t0 = cyc;
    b1.cpu_req = 1'b1; b1.cpu_addr = 5'd1;
    b1.dma_req = 1'b1; b1.dma_addr = 5'd2;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      check_eq("rr_gnt_excl", {31'd0, b1.cpu_gnt & b1.dma_gnt}, 32'd0);
      if (b1.cpu_gnt || b1.dma_gnt) begin
        if (ng < 4) begin gcyc[ng] = cyc; gwho[ng] = b1.dma_gnt; end
        ng++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_who", {31'd0, gwho[k]}, k % 2);
      check_eq("rr_cyc", gcyc[k], t0 + 1 + 4 * k);
    end
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("reset_after_rr");
    model_reset();

    run_round(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    check_eq("t1_rdata_a3", b1.rdata, 8'hA3);
    run_round(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'h1F, 8'h5C, 1'b0);
    check_eq("t2_rdata_kept", b1.rdata, 8'hA3);
    run_round(1'b1, 1'b0, 5'h1F, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    check_eq("t6_readback_5c", b1.rdata, 8'h5C);

    // Reset while the CPU read is waiting on memory
    t0 = cyc;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 5'd5;
    @(posedge clk); #1;
    check_eq("rst_pre_gnt", {31'd0, b1.cpu_gnt}, 32'd1);
    b1.cpu_req = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pre_wait", {b1.busy, b1.mem_rd, b1.cpu_done}, 3'b100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("rst_mid");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check_eq("rst_no_done", {b1.cpu_done, b1.busy, b1.mem_rd, b1.mem_wr}, 4'b0000);
    end
    model_reset();
    run_round(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 2);
      run_round(mode != 1, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom),
                mode != 0, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom), 1'b0);
    end

    run3(1'b0, 5'd5, 8'h00);
    run3(1'b1, 5'd9, 8'h3C);
    run3(1'b0, 5'd9, 8'h00);
    for (int r = 0; r < 6; r++) begin
      run3(1'($urandom), 5'($urandom_range(8, 11)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
